// File: rtl/mac_result_writer.sv
// mac_result_writer
//   Sits downstream of the 4-lane MAC ALU. Each capture strobe latches the
//   four mul-sum results and writes them to the result SRAM, one word per
//   cycle, at grp*4 + 0..3. grp walks the column groups of a matrix, and
//   mat_done marks the last write of the final group. A one-deep pending bank
//   holds the next capture while the current burst drains. If a capture
//   arrives while the pending bank is full, that capture is lost and ovf_err
//   is set.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   cap_valid  capture strobe (ALU web), one cycle wide
//   mu1..mu4   MAC results, lanes 1..4 (MU_W bits each)
//   cap_ready  capture is accepted this cycle (pending bank empty)
//   ram_we     SRAM write enable
//   ram_addr   SRAM write address (ADDR_W bits)
//   ram_wdata  SRAM write data (MU_W bits)
//   busy       burst in progress
//   mat_done   one-cycle pulse on the last write of group COLS-1
//   ovf_err    sticky, set when a capture is lost; cleared only by rst
module mac_result_writer #(
  parameter int unsigned MU_W   = 20,
  parameter int unsigned COLS   = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid,
  input  logic [MU_W-1:0]   mu1,
  input  logic [MU_W-1:0]   mu2,
  input  logic [MU_W-1:0]   mu3,
  input  logic [MU_W-1:0]   mu4,
  output logic              cap_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [MU_W-1:0]   ram_wdata,
  output logic              busy,
  output logic              mat_done,
  output logic              ovf_err
);

  localparam int unsigned GRP_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [GRP_W-1:0] grp, grp_n;
  logic             p_valid, p_valid_n;
  logic [MU_W-1:0]  h [4];
  logic [MU_W-1:0]  p [4];
  logic [MU_W-1:0]  mu [4];

  logic accept;
  logic drop;
  logic last_wr;
  logic grp_last;
  logic load_h_mu;
  logic load_h_p;
  logic load_p;

  always_comb begin
    mu[0] = mu1;
    mu[1] = mu2;
    mu[2] = mu3;
    mu[3] = mu4;
  end

  always_comb begin
    cap_ready = !p_valid;
    accept    = cap_valid && !p_valid;
    drop      = cap_valid && p_valid;
    last_wr   = (state == WRITE) && (idx == 2'd3);
    grp_last  = (grp == GRP_W'(COLS - 1));
  end

  // Next-state logic. The pending bank is used only while a burst is still
  // in progress. On the last write, a capture that arrives in the same cycle
  // goes straight into H, so back-to-back bursts run with no idle cycle.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    grp_n     = grp;
    p_valid_n = p_valid;
    load_h_mu = 1'b0;
    load_h_p  = 1'b0;
    load_p    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load_h_mu = 1'b1;
          idx_n     = 2'd0;
          state_n   = WRITE;
        end
      end
      WRITE: begin
        if (idx != 2'd3) begin
          idx_n = idx + 2'd1;
          if (accept) begin
            load_p    = 1'b1;
            p_valid_n = 1'b1;
          end
        end else begin
          grp_n = grp_last ? '0 : grp + GRP_W'(1);
          idx_n = 2'd0;
          if (p_valid) begin
            load_h_p  = 1'b1;
            p_valid_n = 1'b0;
          end else if (accept) begin
            load_h_mu = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      grp     <= '0;
      p_valid <= 1'b0;
      ovf_err <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        h[i] <= '0;
        p[i] <= '0;
      end
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      grp     <= grp_n;
      p_valid <= p_valid_n;
      if (drop) begin
        ovf_err <= 1'b1;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (load_h_mu) begin
          h[i] <= mu[i];
        end else if (load_h_p) begin
          h[i] <= p[i];
        end
        if (load_p) begin
          p[i] <= mu[i];
        end
      end
    end
  end

  // Outputs come only from registered state.
  // grp*4 + idx is the concatenation {grp, idx}.
  always_comb begin
    ram_we    = (state == WRITE);
    busy      = (state == WRITE);
    ram_addr  = ADDR_W'({grp, idx});
    ram_wdata = h[idx];
    mat_done  = last_wr && grp_last;
  end

endmodule

// File: doc/mac_result_writer.md
Name: mac_result_writer

Overview:
- Downstream stage of the 4-lane MAC ALU.
- When the ALU pulses its finish/web strobe, this block captures the four 20-bit mul-sum results MU1..MU4 and serialises them into the result SRAM, one word per cycle, with address generation.
- Tracks the column group within a matrix and flags matrix completion.
- Has a one-deep pending bank, so the ALU can start the next column while the previous results are still being written.

Parameters:
- MU_W, 20, width of each MAC result and of the SRAM write word.
- COLS, 4, column groups per matrix; each group contributes 4 results.
- ADDR_W, 4, SRAM address width; must satisfy 2^ADDR_W >= 4*COLS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cap_valid  in  1  capture strobe; connected to the ALU web, one cycle wide.
- mu1  in  MU_W  MAC result lane 1.
- mu2  in  MU_W  MAC result lane 2.
- mu3  in  MU_W  MAC result lane 3.
- mu4  in  MU_W  MAC result lane 4.
- cap_ready  out  1  high when a capture is accepted this cycle (= !p_valid).
- ram_we  out  1  SRAM write enable.
- ram_addr  out  ADDR_W  SRAM write address.
- ram_wdata  out  MU_W  SRAM write data.
- busy  out  1  high in WRITE state.
- mat_done  out  1  one-cycle pulse on the last write of group COLS-1.
- ovf_err  out  1  sticky; set when a capture is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled at rising clk.
- Reset values: state=IDLE, idx=0, grp=0, p_valid=0, holding bank H and pending bank P cleared, ovf_err=0.
- Outputs during reset: ram_we=0, ram_addr=0, ram_wdata=0, busy=0, mat_done=0, cap_ready=1.
- Reset mid-write aborts the remaining writes. No ram_we is issued in the cycle after the reset edge.
- Internal state: states IDLE and WRITE; idx is a 2-bit word index; grp is a group counter 0..COLS-1.
- Output decode: ram_we, ram_addr, ram_wdata, busy and mat_done are combinational from registered state only. They do not depend on the same-cycle inputs.
  - ram_we = (state==WRITE).
  - ram_addr = grp*4 + idx, truncated to ADDR_W.
  - ram_wdata = H[idx], with H[0..3] = mu1..mu4.
- Accept condition: cap_valid && cap_ready.
- IDLE:
  - Accepted capture at edge k loads H from mu1..mu4, sets idx=0 and goes to WRITE.
  - The RAM samples writes at edges k+1, k+2, k+3, k+4 (addresses grp*4+0..3). Latency is 1 cycle; the burst is 4 cycles.
- WRITE, idx<3:
  - idx increments each edge.
  - An accepted capture loads P and sets p_valid=1.
- WRITE, idx==3 (last write):
  - grp increments, wrapping from COLS-1 to 0.
  - If p_valid: H<=P, p_valid<=0, idx<=0, stay in WRITE.
  - Else if a capture is accepted in this same cycle: load H directly from mu1..mu4, idx<=0, stay in WRITE. P is not used.
  - Else go to IDLE.
  - Result: back-to-back captures every 4 cycles give continuous ram_we with no bubble.
- mat_done = (state==WRITE && idx==3 && grp==COLS-1).
- Drops: cap_valid while !cap_ready drops the capture. H, P and the write sequence are unaffected, and ovf_err<=1 until rst.
- Width: values pass through unmodified at MU_W bits; no saturation or truncation.

Test Plan:
1. Single capture: after reset, pulse cap_valid with mu1..mu4 = 1,2,3,4 -> ram_we high 4 cycles, addr 0,1,2,3, data 1,2,3,4; busy low afterwards; grp=1; mat_done stays 0.
2. Full matrix: 4 captures of {10k+1..10k+4} for k=0..3, spaced 8 cycles apart -> 16 writes to addr 0..15 with the matching data; mat_done pulses once, on the addr-15 write; the next capture writes addr 0.
3. Back-to-back: capture exactly on the last write cycle, and also one capture 1 cycle after the first -> continuous ram_we with no gap; pending data {5,6,7,8} written to the next group addresses; ovf_err=0.
4. Overflow: third capture while p_valid=1 (cap_ready=0) -> capture dropped, no extra writes, ovf_err=1 and held until rst.
5. Reset mid-burst: assert rst after the 2nd write of a burst -> ram_we=0 from the next cycle; all outputs at reset values; the next capture writes addr 0.
6. Max values: mu = 20'hFFFFF, 20'h80000, 0, 20'h00001 -> ram_wdata exact, no truncation.
